// File: rtl/uart_tx_fifo_reader_if.sv
// FIFO read-port bundle between a byte FIFO and its UART transmit consumer.
// The consumer (master) drives the read strobe; the FIFO (slave) returns empty and data.
interface uart_tx_fifo_reader_if;
   logic       fifo_empty;
   logic [7:0] fifo_rdata;
   logic       fifo_rd;

   modport master (
      input  fifo_empty,
      input  fifo_rdata,
      output fifo_rd
   );

   modport slave (
      output fifo_empty,
      output fifo_rdata,
      input  fifo_rd
   );
endinterface

// File: rtl/uart_tx_fifo_reader.sv
// Pops bytes from a FIFO read port one at a time and sends each as a UART 8N1/8N2 frame,
// LSB first. All outputs are registered; a frame is never interrupted by a FIFO read.
module uart_tx_fifo_reader #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   uart_tx_fifo_reader_if.master        fifo,
   output logic                         tx,
   output logic                         busy,
   output logic                         tx_done
);

   localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BaudW-1:0] BaudLast   = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [BaudW-1:0] BaudPenult = BaudW'(CLKS_PER_BIT - 2);
   localparam logic             StopLast   = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StLatch,
      StStart,
      StData,
      StStop
   } state_e;

   state_e            state_q, state_d;
   logic [BaudW-1:0]  baud_q, baud_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic              stop_q, stop_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              rd_q, rd_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic baud_wrap;
   assign baud_wrap = (baud_q == BaudLast);

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      stop_d    = stop_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      rd_d      = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            tx_d   = 1'b1;
            baud_d = '0;
            if (!fifo.fifo_empty) begin
               rd_d    = 1'b1;
               busy_d  = 1'b1;
               state_d = StRd;
            end
         end
         // The FIFO updates rdata on the edge that leaves this state.
         StRd: begin
            state_d = StLatch;
         end
         StLatch: begin
            shift_d = fifo.fifo_rdata;
            tx_d    = 1'b0;
            baud_d  = '0;
            state_d = StStart;
         end
         StStart: begin
            if (baud_wrap) begin
               baud_d    = '0;
               tx_d      = shift_q[0];
               bit_idx_d = '0;
               state_d   = StData;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StData: begin
            if (baud_wrap) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  tx_d      = 1'b1;
                  stop_d    = 1'b0;
                  bit_idx_d = '0;
                  state_d   = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StStop: begin
            tx_d = 1'b1;
            // Raised one edge early so the registered pulse lands on the final stop cycle.
            if ((stop_q == StopLast) && (baud_q == BaudPenult)) begin
               done_d = 1'b1;
            end
            if (baud_wrap) begin
               baud_d = '0;
               if (stop_q == StopLast) begin
                  stop_d  = 1'b0;
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         baud_q    <= '0;
         bit_idx_q <= '0;
         stop_q    <= 1'b0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         rd_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         stop_q    <= stop_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         rd_q      <= rd_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign fifo.fifo_rd = rd_q;
   assign tx           = tx_q;
   assign busy         = busy_q;
   assign tx_done      = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Bench for uart_tx_fifo_reader: two instances (1 and 2 stop bits) fed by queue-modelled FIFOs,
// with an expected-byte scoreboard compared against per-cycle captured frames.
module tb_uart_tx_fifo_reader;

   localparam int unsigned Cpb = 4;

   logic clk;
   logic rst_n;
   logic tx1, busy1, done1;
   logic tx2, busy2, done2;

   uart_tx_fifo_reader_if if1 ();
   uart_tx_fifo_reader_if if2 ();

   uart_tx_fifo_reader #(.CLKS_PER_BIT(Cpb), .STOP_BITS(1)) dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .fifo    (if1.master),
      .tx      (tx1),
      .busy    (busy1),
      .tx_done (done1)
   );

   uart_tx_fifo_reader #(.CLKS_PER_BIT(Cpb), .STOP_BITS(2)) dut2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .fifo    (if2.master),
      .tx      (tx2),
      .busy    (busy2),
      .tx_done (done2)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;
   int rd_cnt1   = 0;
   int rd_cnt2   = 0;
   int rd_double = 0;
   int rd_bad    = 0;
   logic rd_prev1 = 1'b0, rd_prev2 = 1'b0;
   logic empty_prev1 = 1'b1, empty_prev2 = 1'b1;

   logic [7:0] fq1[$];
   logic [7:0] fq2[$];
   logic [7:0] exp1[$];
   logic [7:0] exp2[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // FIFO models: rdata updates on the edge that samples rd; empty is registered.
   always @(posedge clk) begin
      if (if1.fifo_rd && fq1.size() > 0) if1.fifo_rdata <= fq1.pop_front();
      if1.fifo_empty <= (fq1.size() == 0);
      if (if2.fifo_rd && fq2.size() > 0) if2.fifo_rdata <= fq2.pop_front();
      if2.fifo_empty <= (fq2.size() == 0);
   end

   // rd-pulse bookkeeping; empty seen at the prior negedge is what the DUT sampled.
   always @(negedge clk) begin
      if (if1.fifo_rd === 1'b1) begin
         rd_cnt1++;
         if (rd_prev1) rd_double++;
         if (empty_prev1 !== 1'b0) rd_bad++;
      end
      if (if2.fifo_rd === 1'b1) begin
         rd_cnt2++;
         if (rd_prev2) rd_double++;
         if (empty_prev2 !== 1'b0) rd_bad++;
      end
      rd_prev1    = (if1.fifo_rd === 1'b1);
      rd_prev2    = (if2.fifo_rd === 1'b1);
      empty_prev1 = if1.fifo_empty;
      empty_prev2 = if2.fifo_empty;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic get_tx(input int sel);
      return (sel == 2) ? tx2 : tx1;
   endfunction

   function automatic logic get_busy(input int sel);
      return (sel == 2) ? busy2 : busy1;
   endfunction

   function automatic logic get_done(input int sel);
      return (sel == 2) ? done2 : done1;
   endfunction

   function automatic logic [63:0] exp_wave(input logic [7:0] b, input int stops);
      logic [63:0] w;
      w = '0;
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < 4; j++) w[4 + 4 * k + j] = b[k];
      for (int j = 0; j < 4 * stops; j++) w[36 + j] = 1'b1;
      return w;
   endfunction

   function automatic logic [63:0] exp_done(input int len);
      logic [63:0] w;
      w = '0;
      w[len - 1] = 1'b1;
      return w;
   endfunction

   function automatic logic [63:0] exp_busy(input int len);
      logic [63:0] w;
      w = '0;
      for (int i = 0; i < len; i++) w[i] = 1'b1;
      return w;
   endfunction

   task automatic push_byte(input int sel, input logic [7:0] b);
      if (sel == 2) begin
         fq2.push_back(b);
         exp2.push_back(b);
      end else begin
         fq1.push_back(b);
         exp1.push_back(b);
      end
   endtask

   // Waits (bounded) for the start bit, then records len cycles of tx/tx_done/busy.
   task automatic capture(input int sel, input int len, output logic [63:0] txw,
                          output logic [63:0] dnw, output logic [63:0] bsw, output bit timeout);
      int n;
      n = 0;
      txw = '0;
      dnw = '0;
      bsw = '0;
      timeout = 1'b0;
      while (get_tx(sel) !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (get_tx(sel) !== 1'b0) begin
         timeout = 1'b1;
         return;
      end
      for (int i = 0; i < len; i++) begin
         txw[i] = get_tx(sel);
         dnw[i] = get_done(sel);
         bsw[i] = get_busy(sel);
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if (tx1 !== 1'b1 || tx2 !== 1'b1) $display("FAIL reset_tx: got %b/%b want 1/1", tx1, tx2);
      else pass_cnt++;
      total_cnt++;
      if (if1.fifo_rd !== 1'b0) $display("FAIL reset_rd: got %b want 0", if1.fifo_rd);
      else pass_cnt++;
      total_cnt++;
      if (busy1 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy1);
      else pass_cnt++;
      total_cnt++;
      if (done1 !== 1'b0) $display("FAIL reset_done: got %b want 0", done1);
      else pass_cnt++;
      rst_n = 1'b1;
      // Asynchronous reset while a frame is being sent.
      push_byte(1, 8'h11);
      n = 0;
      while (tx1 !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      total_cnt++;
      if (tx1 !== 1'b0 || busy1 !== 1'b1)
         $display("FAIL async_pre: got tx=%b busy=%b want tx=0 busy=1", tx1, busy1);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if (tx1 !== 1'b1 || busy1 !== 1'b0)
         $display("FAIL async_reset: got tx=%b busy=%b want tx=1 busy=0", tx1, busy1);
      else pass_cnt++;
      if (exp1.size() > 0) void'(exp1.pop_front());
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      logic [63:0] txw, dnw, bsw;
      bit          to;
      logic [7:0]  e;
      int          rd0;
      rd0 = rd_cnt1;
      push_byte(1, 8'hA5);
      capture(1, 40, txw, dnw, bsw, to);
      e = (exp1.size() > 0) ? exp1.pop_front() : 8'h00;
      total_cnt++;
      if (to) $display("FAIL single_start: got no start bit want start within 400 cycles");
      else pass_cnt++;
      total_cnt++;
      if (txw !== exp_wave(e, 1)) $display("FAIL single_tx: got %h want %h", txw, exp_wave(e, 1));
      else pass_cnt++;
      total_cnt++;
      if (dnw !== exp_done(40)) $display("FAIL single_done: got %h want %h", dnw, exp_done(40));
      else pass_cnt++;
      total_cnt++;
      if (bsw !== exp_busy(40) || busy1 !== 1'b0)
         $display("FAIL single_busy: got %h/%b want %h/0", bsw, busy1, exp_busy(40));
      else pass_cnt++;
      total_cnt++;
      if (rd_cnt1 - rd0 != 1) $display("FAIL single_rd_count: got %0d want 1", rd_cnt1 - rd0);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [63:0] txw, dnw, bsw;
      bit          to;
      logic [7:0]  e;
      int          rd0, gap;
      rd0 = rd_cnt1;
      push_byte(1, 8'h00);
      push_byte(1, 8'hFF);
      for (int f = 0; f < 2; f++) begin
         capture(1, 40, txw, dnw, bsw, to);
         e = (exp1.size() > 0) ? exp1.pop_front() : 8'h00;
         total_cnt++;
         if (to || txw !== exp_wave(e, 1))
            $display("FAIL b2b_frame%0d: got %h want %h", f, txw, exp_wave(e, 1));
         else pass_cnt++;
         total_cnt++;
         if (dnw !== exp_done(40)) $display("FAIL b2b_done%0d: got %h want %h", f, dnw, exp_done(40));
         else pass_cnt++;
         if (f == 0) begin
            gap = 0;
            while (tx1 === 1'b1 && gap < 20) begin
               gap++;
               @(negedge clk);
            end
            total_cnt++;
            if (gap != 3) $display("FAIL b2b_gap: got %0d idle cycles want 3", gap);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (rd_cnt1 - rd0 != 2) $display("FAIL b2b_rd_count: got %0d want 2", rd_cnt1 - rd0);
      else pass_cnt++;
   endtask

   task automatic test_empty_idle();
      int bad_rd, bad_tx, bad_busy;
      bad_rd = 0;
      bad_tx = 0;
      bad_busy = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (if1.fifo_rd !== 1'b0) bad_rd++;
         if (tx1 !== 1'b1) bad_tx++;
         if (busy1 !== 1'b0) bad_busy++;
      end
      total_cnt++;
      if (bad_rd != 0) $display("FAIL empty_rd: got %0d rd cycles want 0", bad_rd);
      else pass_cnt++;
      total_cnt++;
      if (bad_tx != 0) $display("FAIL empty_tx: got %0d low cycles want 0", bad_tx);
      else pass_cnt++;
      total_cnt++;
      if (bad_busy != 0) $display("FAIL empty_busy: got %0d busy cycles want 0", bad_busy);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_frame();
      logic [63:0] txw, dnw, bsw;
      bit          to;
      logic [7:0]  e;
      int          n, rd0, bad;
      push_byte(1, 8'h3C);
      n = 0;
      while (tx1 !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (17) @(negedge clk);  // inside data bit 3
      total_cnt++;
      if (busy1 !== 1'b1) $display("FAIL midrst_pre: got busy=%b want 1", busy1);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if (tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0)
         $display("FAIL midrst_async: got tx=%b busy=%b done=%b want 1/0/0", tx1, busy1, done1);
      else pass_cnt++;
      if (exp1.size() > 0) void'(exp1.pop_front());
      @(negedge clk);
      rst_n = 1'b1;
      rd0 = rd_cnt1;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx1 !== 1'b1) bad++;
      end
      total_cnt++;
      if (rd_cnt1 != rd0 || bad != 0)
         $display("FAIL midrst_quiet: got rd=%0d low=%0d want 0/0", rd_cnt1 - rd0, bad);
      else pass_cnt++;
      push_byte(1, 8'h5A);
      capture(1, 40, txw, dnw, bsw, to);
      e = (exp1.size() > 0) ? exp1.pop_front() : 8'h00;
      total_cnt++;
      if (to || txw !== exp_wave(e, 1))
         $display("FAIL midrst_next: got %h want %h", txw, exp_wave(e, 1));
      else pass_cnt++;
      total_cnt++;
      if (rd_cnt1 - rd0 != 1) $display("FAIL midrst_rd_count: got %0d want 1", rd_cnt1 - rd0);
      else pass_cnt++;
   endtask

   task automatic test_two_stop();
      logic [63:0] txw, dnw, bsw;
      bit          to;
      logic [7:0]  e;
      int          rd0;
      rd0 = rd_cnt2;
      push_byte(2, 8'h81);
      capture(2, 44, txw, dnw, bsw, to);
      e = (exp2.size() > 0) ? exp2.pop_front() : 8'h00;
      total_cnt++;
      if (to || txw !== exp_wave(e, 2))
         $display("FAIL stop2_tx: got %h want %h", txw, exp_wave(e, 2));
      else pass_cnt++;
      total_cnt++;
      if (dnw !== exp_done(44)) $display("FAIL stop2_done: got %h want %h", dnw, exp_done(44));
      else pass_cnt++;
      total_cnt++;
      if (bsw !== exp_busy(44) || busy2 !== 1'b0)
         $display("FAIL stop2_busy: got %h/%b want %h/0", bsw, busy2, exp_busy(44));
      else pass_cnt++;
      total_cnt++;
      if (rd_cnt2 - rd0 != 1) $display("FAIL stop2_rd_count: got %0d want 1", rd_cnt2 - rd0);
      else pass_cnt++;
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_empty_idle();
      test_reset_mid_frame();
      test_two_stop();
      total_cnt++;
      if (rd_double != 0) $display("FAIL rd_single_cycle: got %0d repeats want 0", rd_double);
      else pass_cnt++;
      total_cnt++;
      if (rd_bad != 0) $display("FAIL rd_when_empty: got %0d want 0", rd_bad);
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
